neuron_mac_acc: RTL and testbench



---
 rtl/neuron_mac_acc.sv | 124 ++++++++++++
 tb/tb_neuron_mac_acc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_acc.sv
// neuron_mac_acc: sequential MAC neuron stage.
// K signed pairs plus bias, rescaled, saturated, optional ReLU.
module neuron_mac_acc #(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int FRAC  = 4,
  parameter int ACC_W = 20,
  parameter int RELU  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic signed [N-1:0] X,
  input  logic signed [N-1:0] W,
  input  logic signed [N-1:0] BIAS,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic        [N-1:0] Y,
  output logic                SAT
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic signed [ACC_W-1:0] RMAX =
    ACC_W'((2 ** (N - 1)) - 1);
  localparam logic signed [ACC_W-1:0] RMIN = ~RMAX;

  if (ACC_W < 2 * N + $clog2(K) + 1) begin : g_accw_chk
    $error("neuron_mac_acc: ACC_W too small");
  end

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_t;

  state_t state, state_n;

  logic signed [ACC_W-1:0] acc;
  logic        [CW-1:0]    cnt;

  logic                    beat;
  logic                    last;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] bias_x;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] r;
  logic        [N-1:0]     y_n;
  logic                    sat_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_ACC;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (state)
      S_ACC: begin
        IN_READY = 1'b1;
        if (IN_VALID && last) state_n = S_OUT;
      end
      S_OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_n = S_ACC;
      end
      default: state_n = S_ACC;
    endcase
  end

  assign beat = IN_VALID & IN_READY;
  assign last = (cnt == CW'(K - 1));

  // Full-width signed product, sign-extended into the accumulator.
  always_comb begin
    prod   = $signed({{N{X[N-1]}}, X})
           * $signed({{N{W[N-1]}}, W});
    prod_x = ACC_W'(prod);
    bias_x = ACC_W'(BIAS) <<< FRAC;
    if (cnt == '0) sum = bias_x + prod_x;
    else           sum = acc + prod_x;
    r = sum >>> FRAC;
  end

  always_comb begin
    y_n   = r[N-1:0];
    sat_n = 1'b0;
    if (r > RMAX) begin
      y_n   = RMAX[N-1:0];
      sat_n = 1'b1;
    end else if (r < RMIN) begin
      y_n   = RMIN[N-1:0];
      sat_n = 1'b1;
    end
    // ReLU wins over saturation on the negative side.
    if (RELU != 0 && y_n[N-1]) begin
      y_n   = '0;
      sat_n = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      cnt <= '0;
      Y   <= '0;
      SAT <= 1'b0;
    end else if (beat) begin
      acc <= sum;
      if (last) begin
        cnt <= '0;
        Y   <= y_n;
        SAT <= sat_n;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// tb_neuron_mac_acc: directed bench, RELU=1 and RELU=0
// instances share one stimulus stream.
module tb_neuron_mac_acc;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         OUT_READY = 1'b0;
  logic [N-1:0] X = '0;
  logic [N-1:0] W = '0;
  logic [N-1:0] BIAS = '0;

  logic         rdy1, rdy0, ov1, ov0, sat1, sat0;
  logic [N-1:0] y1, y0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  neuron_mac_acc #(
    .N(8), .K(4), .FRAC(4), .ACC_W(20), .RELU(1)
  ) d1 (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(rdy1),
    .X(X), .W(W), .BIAS(BIAS),
    .OUT_VALID(ov1), .OUT_READY(OUT_READY),
    .Y(y1), .SAT(sat1)
  );

  neuron_mac_acc #(
    .N(8), .K(4), .FRAC(4), .ACC_W(20), .RELU(0)
  ) d0 (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(rdy0),
    .X(X), .W(W), .BIAS(BIAS),
    .OUT_VALID(ov0), .OUT_READY(OUT_READY),
    .Y(y0), .SAT(sat0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input int x, input int w,
                      input int b);
    IN_VALID = 1'b1;
    X = N'(x);
    W = N'(w);
    BIAS = N'(b);
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic both(input string tag,
                      input logic [N-1:0] e1,
                      input logic [N-1:0] e0,
                      input logic s1, input logic s0);
    chk({tag, "_ov1"}, ov1, 1'b1);
    chk({tag, "_ov0"}, ov0, 1'b1);
    chk({tag, "_y1"}, y1, e1);
    chk({tag, "_y0"}, y0, e0);
    chk({tag, "_sat1"}, sat1, s1);
    chk({tag, "_sat0"}, sat0, s0);
  endtask

  task automatic consume(input string tag);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, "_ovlow"}, ov1, 1'b0);
    chk({tag, "_rdy"}, rdy1, 1'b1);
  endtask

  initial begin
    #1 RST = 1'b1;
    #1;
    chk("rst_rdy", rdy1, 1'b1);
    chk("rst_ov", ov1, 1'b0);
    chk("rst_y", y1, 8'h00);
    chk("rst_sat", sat1, 1'b0);
    tick();
    RST = 1'b0;
    tick();

    // basic: 4 * 256 = 1024 -> 64
    repeat (3) beat(16, 16, 0);
    chk("basic_lat", ov1, 1'b0);
    beat(16, 16, 0);
    both("basic", 8'd64, 8'd64, 1'b0, 1'b0);
    consume("basic");

    // bias 8 -> 128 + 256 = 384 -> 24
    beat(16, 16, 8);
    repeat (3) beat(0, 5, 99);
    both("bias", 8'd24, 8'd24, 1'b0, 1'b0);
    consume("bias");

    // 4 * 16129 = 64516 -> 4032 -> 127
    repeat (4) beat(127, 127, 0);
    both("satp", 8'd127, 8'd127, 1'b1, 1'b1);
    consume("satp");

    // 4 * -16256 -> -4064 -> -128 (ReLU -> 0)
    repeat (4) beat(-128, 127, 0);
    both("satn", 8'h00, 8'h80, 1'b0, 1'b1);
    consume("satn");

    // 4 * -256 -> -64
    repeat (4) beat(-16, 16, 0);
    both("relu", 8'h00, 8'hC0, 1'b0, 1'b0);
    consume("relu");

    // stall: 128 + 1024 = 1152 -> 72
    repeat (4) beat(16, 16, 8);
    both("hs", 8'd72, 8'd72, 1'b0, 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      X = N'(i * 7 + 1);
      W = 8'd3;
      tick();
      chk("hs_ov", ov1, 1'b1);
      chk("hs_rdy", rdy1, 1'b0);
      chk("hs_y", y1, 8'd72);
      chk("hs_sat", sat1, 1'b0);
    end
    X = 8'd100;
    W = 8'd100;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;
    chk("hs_rel_ov", ov1, 1'b0);
    chk("hs_rel_rdy", rdy1, 1'b1);
    // 4 * 128 = 512 -> 32
    repeat (3) beat(8, 16, 0);
    chk("hs_cnt", ov1, 1'b0);
    beat(8, 16, 0);
    both("hs_next", 8'd32, 8'd32, 1'b0, 1'b0);
    consume("hs_next");

    // gaps: same operands as the stall run -> 72
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 3)) begin
        X = N'($urandom);
        W = N'($urandom);
        tick();
      end
      if (i == 3) chk("gap_lat", ov1, 1'b0);
      beat(16, 16, (i == 0) ? 8 : 99);
    end
    both("gap", 8'd72, 8'd72, 1'b0, 1'b0);
    consume("gap");

    // reset mid-evaluation
    repeat (2) beat(16, 16, 0);
    #2 RST = 1'b1;
    #1;
    chk("rmid_rdy", rdy1, 1'b1);
    chk("rmid_ov", ov1, 1'b0);
    chk("rmid_y", y1, 8'h00);
    tick();
    RST = 1'b0;
    repeat (3) beat(16, 16, 0);
    chk("rmid_cnt", ov1, 1'b0);
    beat(16, 16, 0);
    both("rmid", 8'd64, 8'd64, 1'b0, 1'b0);

    // reset discards pending output
    #2 RST = 1'b1;
    #1;
    chk("rout_ov", ov1, 1'b0);
    chk("rout_rdy", rdy1, 1'b1);
    chk("rout_y", y1, 8'h00);
    tick();
    RST = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
